bfm_sync_fifo: RTL and testbench
================================

# bfm_sync_fifo

Synchronous single-clock FIFO used inside the IEEE1355 bus functional model as both the RX store and the TX store. Data enters through a write strobe or through a simulation task that lets the testbench preload words, and leaves through a first-word-fall-through read port. A registered occupancy count is exported so the link logic can snapshot how many words to send.

## Interface
- `G_DATA_WIDTH_BITS`, default 8: width of each stored word.
- `G_ADDR_WIDTH_BITS`, default 6: address width. Depth is 2^G_ADDR_WIDTH_BITS words (64 by default).
- `clk`, in, 1: single clock. All state changes happen on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `w_en`, in, 1: write strobe. Stores `w_data` at the rising edge.
- `w_data`, in, G_DATA_WIDTH_BITS: write data.
- `r_en`, in, 1: read/pop strobe. Consumes the current head word at the rising edge.
- `r_data`, out, G_DATA_WIDTH_BITS: current head word, first-word fall-through.
- `fill_level`, out, G_ADDR_WIDTH_BITS+1: number of words stored, range 0..2^G_ADDR_WIDTH_BITS.
- Task `insert_fifo_data(input [G_DATA_WIDTH_BITS-1:0] d)`: simulation-only. Enqueues one word.

## Operation
- Storage is a circular buffer with write and read pointers, each G_ADDR_WIDTH_BITS wide. Both pointers wrap modulo depth.
- `fill_level` is a separate counter, G_ADDR_WIDTH_BITS+1 bits wide, so the full state is distinguishable from empty.
- `r_data` is driven combinationally from the memory location at the read pointer.
  - When the FIFO is not empty, `r_data` always equals the oldest word, with no read latency.
  - The consumer samples `r_data` in the same cycle it asserts `r_en`.
- Write accepted: `w_en`=1 and (not full, or a read is accepted in the same cycle). The word is stored and the write pointer advances.
- Write to a full FIFO with no accepted read: the word is silently dropped and no state changes.
- Read accepted: `r_en`=1 and fill_level>0. The read pointer advances.
- Read from an empty FIFO: ignored. No pointer movement, no underflow. `r_data` is don't-care.
- Simultaneous accepted read and write: both pointers advance and `fill_level` is unchanged.
  - When full, simultaneous r_en and w_en are both accepted.
  - When empty, only the write is accepted.
- `insert_fifo_data`:
  - Waits for the first rising edge of `clk` at which `w_en`=0, then performs exactly one write with the same full/drop rules as a port write.
  - The word is counted in `fill_level` after that edge.
  - The task returns after the edge.
  - Calls are serialised in call order.
- No status outputs other than `fill_level`. The consumer derives empty from `fill_level`==0 and full from `fill_level`==2^G_ADDR_WIDTH_BITS.

## Timing
- Reset (rst=1 at a rising edge): write pointer, read pointer and `fill_level` go to 0.
  - Memory contents are not cleared. `r_data` is undefined until the first write.
  - Reset mid-operation discards all stored words within that edge.
- Write-to-visibility:
  - A word written at edge N appears on `r_data` immediately after edge N if the FIFO was empty.
  - `fill_level` reflects the word after edge N, a one-edge latency.
- Read: popping at edge N updates `r_data` to the next word and decrements `fill_level` right after edge N.
- `fill_level` is registered and never glitches. It changes by at most ±1 per edge.
- Pointer wrap from depth-1 to 0 is seamless, with no bubble cycle.

## Structure
- No shared package is needed. Width and depth come from the parameters only.
- Single flat module: one memory array, two pointers, one counter and the task. No sub-module.

## Test plan
- Reset, then 3 port writes (0xA1, 0xB2, 0xC3):
  - `fill_level` steps 1, 2, 3.
  - `r_data`=0xA1 after the first write.
  - Three pops return 0xA1, 0xB2, 0xC3 and `fill_level` returns to 0.
- Call `insert_fifo_data` with 0x55 then 0x66 while `w_en`=0: `fill_level`=2 and `r_data`=0x55.
- Fill 64 words (0x00..0x3F):
  - `fill_level`=64.
  - A 65th write of 0xFF is dropped.
  - Draining yields 0x00..0x3F in order.
- Full FIFO with r_en and w_en both high, w_data=0x99:
  - `fill_level` stays 64.
  - Head advances to 0x01.
  - 0x99 is read last.
- Empty FIFO, pop attempted: `fill_level` stays 0. A subsequent write of 0x12 is read back correctly.
- Write 5 words, assert rst for one edge: `fill_level`=0. The next written word 0x7E appears on `r_data`.

Source files
------------

// File: rtl/bfm_sync_fifo.sv
// First-word-fall-through synchronous FIFO for the IEEE1355 BFM RX/TX stores.
// Words arrive on the write port or through insert_fifo_data, which lets a bench preload words.
module bfm_sync_fifo #(
  parameter int unsigned G_DATA_WIDTH_BITS = 8,
  parameter int unsigned G_ADDR_WIDTH_BITS = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         w_en,
  input  logic [G_DATA_WIDTH_BITS-1:0] w_data,
  input  logic                         r_en,
  output logic [G_DATA_WIDTH_BITS-1:0] r_data,
  output logic [G_ADDR_WIDTH_BITS:0]   fill_level
);

  localparam int unsigned DW    = G_DATA_WIDTH_BITS;
  localparam int unsigned AW    = G_ADDR_WIDTH_BITS;
  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Preload path; only the insert task below ever drives these.
  logic          ins_en;
  logic [DW-1:0] ins_data;
  logic          ins_busy;

  logic          full;
  logic          empty;
  logic          wr_req;
  logic          rd_acc;
  logic          wr_acc;
  logic [DW-1:0] wr_word;

  // Acceptance rules; a full FIFO still takes a write when a read frees a slot in the same edge.
  always_comb begin
    full    = 1'b0;
    empty   = 1'b0;
    wr_req  = 1'b0;
    rd_acc  = 1'b0;
    wr_acc  = 1'b0;
    wr_word = w_data;
    full    = (fill_level == (AW+1)'(DEPTH));
    empty   = (fill_level == '0);
    wr_req  = w_en | ins_en;
    if (!w_en) begin
      wr_word = ins_data;
    end
    rd_acc  = r_en & ~empty;
    wr_acc  = wr_req & (~full | rd_acc);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_acc && !rd_acc) begin
        fill_level <= fill_level + (AW+1)'(1);
      end else if (rd_acc && !wr_acc) begin
        fill_level <= fill_level - (AW+1)'(1);
      end
    end
  end

  assign r_data = mem[rd_ptr];

  // Simulation-only preload: rides the first edge with w_en low, then releases the write path.
  task automatic insert_fifo_data(input logic [G_DATA_WIDTH_BITS-1:0] d);
    while (ins_busy == 1'b1) @(posedge clk);
    ins_busy = 1'b1;
    ins_data <= d;
    ins_en   <= 1'b1;
    @(posedge clk iff !w_en);
    ins_en   <= 1'b0;
    ins_busy = 1'b0;
  endtask

endmodule

// File: tb/tb_bfm_sync_fifo.sv
// Bench for bfm_sync_fifo: directed scenarios plus random traffic against a queue model.
module tb_bfm_sync_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          w_en;
  logic [DW-1:0] w_data;
  logic          r_en;
  logic [DW-1:0] r_data;
  logic [AW:0]   fill_level;

  int unsigned   n_checks;
  int unsigned   n_errors;
  logic [DW-1:0] model [$];

  bfm_sync_fifo #(
    .G_DATA_WIDTH_BITS(DW),
    .G_ADDR_WIDTH_BITS(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .w_en      (w_en),
    .w_data    (w_data),
    .r_en      (r_en),
    .r_data    (r_data),
    .fill_level(fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // State after an edge, compared against the queue model.
  task automatic check_state(input string tag);
    chk({tag, "_fill"}, 32'(fill_level), 32'(model.size()));
    if (model.size() > 0) begin
      chk({tag, "_head"}, 32'(r_data), 32'(model[0]));
    end
  endtask

  // One clock: called at a negedge, returns at the next negedge.
  task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re, input string tag);
    bit rd_ok;
    bit wr_ok;
    w_en   = we;
    w_data = wd;
    r_en   = re;
    rd_ok  = re && (model.size() > 0);
    wr_ok  = we && ((model.size() < DEPTH) || rd_ok);
    if (rd_ok) begin
      chk({tag, "_pop"}, 32'(r_data), 32'(model[0]));
    end
    @(posedge clk);
    if (rd_ok) void'(model.pop_front());
    if (wr_ok) model.push_back(wd);
    @(negedge clk);
    w_en = 1'b0;
    r_en = 1'b0;
    check_state(tag);
  endtask

  task automatic do_insert(input logic [DW-1:0] d, input string tag);
    w_en = 1'b0;
    r_en = 1'b0;
    dut.insert_fifo_data(d);
    if (model.size() < DEPTH) model.push_back(d);
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    w_en     = 1'b0;
    w_data   = '0;
    r_en     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();
    chk("reset_fill", 32'(fill_level), 32'd0);

    // Three port writes then three pops.
    cycle(1'b1, 8'hA1, 1'b0, "w1");
    chk("w1_head_const", 32'(r_data), 32'hA1);
    chk("w1_fill_const", 32'(fill_level), 32'd1);
    cycle(1'b1, 8'hB2, 1'b0, "w2");
    cycle(1'b1, 8'hC3, 1'b0, "w3");
    chk("w3_fill_const", 32'(fill_level), 32'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, "pop3");
    chk("pop3_empty", 32'(fill_level), 32'd0);

    // Preload through the task.
    do_insert(8'h55, "ins1");
    do_insert(8'h66, "ins2");
    chk("ins_fill_const", 32'(fill_level), 32'd2);
    chk("ins_head_const", 32'(r_data), 32'h55);
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b1, "ins_drain");

    // Fill to capacity, drop an overflow, drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, "fill");
    chk("full_fill", 32'(fill_level), 32'(DEPTH));
    cycle(1'b1, 8'hFF, 1'b0, "overflow");
    chk("overflow_fill", 32'(fill_level), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 32'(r_data), 32'(i));
      cycle(1'b0, 8'h00, 1'b1, "drain");
    end
    chk("drain_empty", 32'(fill_level), 32'd0);

    // Simultaneous read and write while full.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, "refill");
    cycle(1'b1, 8'h99, 1'b1, "full_rw");
    chk("full_rw_fill", 32'(fill_level), 32'(DEPTH));
    chk("full_rw_head", 32'(r_data), 32'h01);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, "drain2");
    chk("drain2_empty", 32'(fill_level), 32'd0);

    // Pop from empty, then a write still lands correctly; read+write on empty keeps only the write.
    cycle(1'b0, 8'h00, 1'b1, "empty_pop");
    chk("empty_pop_fill", 32'(fill_level), 32'd0);
    cycle(1'b1, 8'h12, 1'b1, "empty_rw");
    chk("empty_rw_head", 32'(r_data), 32'h12);
    chk("empty_rw_fill", 32'(fill_level), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, "empty_rw_pop");

    // Reset mid-operation.
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(8'h20 + i), 1'b0, "pre_rst");
    do_reset();
    chk("mid_rst_fill", 32'(fill_level), 32'd0);
    cycle(1'b1, 8'h7E, 1'b0, "post_rst");
    chk("post_rst_head", 32'(r_data), 32'h7E);

    // Random traffic, biased between fill-heavy and drain-heavy phases.
    for (int ph = 0; ph < 8; ph++) begin
      int unsigned wpct;
      wpct = (ph % 2 == 0) ? 80 : 25;
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 49) == 0) begin
          do_insert(DW'($urandom), "rnd_ins");
        end else begin
          cycle($urandom_range(0, 99) < wpct, DW'($urandom),
                $urandom_range(0, 99) < (100 - wpct), "rnd");
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
